// File: rtl/dp_seq_ctrl.sv
// Dot-product sequencer: streams (unsigned a, signed b) pairs through one
// registered 9x8 signed multiplier and accumulates into a 32-bit signed sum.
//
// state | meaning
// IDLE  | waiting for a start command
// RUN   | accepting element pairs until the count reaches zero
// DRAIN | one cycle for the final registered product to reach the sum
// DONE  | result held on the output until the consumer takes it
module dp_seq_ctrl #(
  parameter int LEN_W = 10
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_len,
  output logic             o_busy,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [7:0]       i_in_a,
  input  logic [7:0]       i_in_b,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [31:0]      o_out_res
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        r_state;
  logic [LEN_W-1:0]  r_remaining;
  logic signed [31:0] r_acc;
  logic signed [16:0] r_prod;
  logic              r_p_vld;

  logic              w_in_hs;
  logic              w_cmd;
  logic signed [16:0] w_prod;
  logic signed [31:0] w_prod_ext;

  assign w_in_hs    = i_in_valid && (r_state == S_RUN);
  assign w_cmd      = i_start && (r_state == S_IDLE);
  assign w_prod     = $signed({1'b0, i_in_a}) * $signed(i_in_b);
  assign w_prod_ext = {{15{r_prod[16]}}, r_prod};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_acc       <= '0;
      r_prod      <= '0;
      r_p_vld     <= 1'b0;
    end else begin
      // p_vld is a one-cycle marker that the product register holds fresh data
      r_p_vld <= w_in_hs;
      if (w_in_hs) begin
        r_prod      <= w_prod;
        r_remaining <= r_remaining - 1'b1;
      end
      if (w_cmd) begin
        r_acc <= '0;
      end else if (r_p_vld) begin
        r_acc <= r_acc + w_prod_ext;
      end
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_remaining <= i_len;
            r_state     <= (i_len == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (w_in_hs && (r_remaining == LEN_W'(1))) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: r_state <= S_DONE;
        S_DONE: begin
          if (i_out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy      = (r_state != S_IDLE);
  assign o_in_ready  = (r_state == S_RUN);
  assign o_out_valid = (r_state == S_DONE);
  // The sum is left untouched after DONE, so it doubles as the held result
  assign o_out_res   = r_acc;

endmodule

// File: tb/tb_dp_seq_ctrl.sv
// Self-checking bench for dp_seq_ctrl: directed vectors plus randomized
// vectors compared against a plain-arithmetic dot-product model.
module tb_dp_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [9:0]  len;
  logic        busy;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_res;

  int n_checks;
  int n_errors;
  logic [7:0] va [16];
  logic [7:0] vb [16];

  dp_seq_ctrl #(.LEN_W(10)) u_dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_len       (len),
    .o_busy      (busy),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_a      (in_a),
    .i_in_b      (in_b),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_res   (out_res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, $signed(obs), obs,
               $signed(exp), exp);
    end
  endtask

  function automatic int smul(input logic [7:0] a, input logic [7:0] b);
    int ia;
    int ib;
    ia = int'(a);
    ib = (int'(b) > 127) ? int'(b) - 256 : int'(b);
    return ia * ib;
  endfunction

  // bmode: 0 = no bubbles, 1 = valid on alternate cycles, 2 = random bubbles
  task automatic run_vec(input int n, input int bmode, input int bp, input bit fixed);
    int sent;
    int hs;
    int cyc;
    int exp_sum;
    bit v;
    sent    = 0;
    hs      = 0;
    exp_sum = 0;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    start     = 1'b1;
    len       = 10'(n);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    chk("busy_after_start", 32'(busy), 32'd1);
    while (!out_valid && cyc < 300) begin
      case (bmode)
        0:       v = 1'b1;
        1:       v = (cyc % 2) == 1;
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      if (sent < n) begin
        in_a = fixed ? va[sent] : 8'($urandom);
        in_b = fixed ? vb[sent] : 8'($urandom);
      end else begin
        v    = 1'b1;
        in_a = 8'($urandom);
        in_b = 8'($urandom);
      end
      in_valid = v;
      if (v && in_ready) begin
        hs++;
        if (sent < n) exp_sum += smul(in_a, in_b);
        sent++;
      end
      start = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    chk("out_valid_seen", 32'(out_valid), 32'd1);
    chk("result", out_res, 32'(exp_sum));
    chk("handshakes", 32'(hs), 32'(n));
    chk("in_ready_done", 32'(in_ready), 32'd0);
    if (bmode == 0) chk("latency", 32'(cyc), (n == 0) ? 32'd1 : 32'(n + 2));
    repeat (bp) begin
      start = 1'($urandom_range(0, 1));
      len   = 10'($urandom_range(0, 16));
      @(negedge clk);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_res", out_res, 32'(exp_sum));
    end
    // start during the output handshake must be ignored
    start     = 1'b1;
    len       = 10'd1;
    out_ready = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    out_ready = 1'b0;
    chk("valid_clear", 32'(out_valid), 32'd0);
    chk("busy_clear", 32'(busy), 32'd0);
    chk("res_hold", out_res, 32'(exp_sum));
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    start     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_res", out_res, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    va[0] = 8'd1; va[1] = 8'd2; va[2] = 8'd3; va[3] = 8'd4;
    vb[0] = 8'd1; vb[1] = 8'hFF; vb[2] = 8'd2; vb[3] = 8'hFE;
    run_vec(4, 0, 0, 1'b1);
    chk("basic_sum", out_res, 32'hFFFF_FFFD);

    for (int i = 0; i < 3; i++) begin va[i] = 8'd255; vb[i] = 8'h80; end
    run_vec(3, 0, 1, 1'b1);
    chk("extreme_neg", out_res, 32'(-97920));
    for (int i = 0; i < 2; i++) begin va[i] = 8'd255; vb[i] = 8'd127; end
    run_vec(2, 0, 0, 1'b1);
    chk("extreme_pos", out_res, 32'd64770);

    run_vec(0, 0, 5, 1'b1);
    chk("zero_len", out_res, 32'd0);

    va[0] = 8'd10; va[1] = 8'd20; va[2] = 8'd30;
    vb[0] = 8'hFB; vb[1] = 8'd5;  vb[2] = 8'd1;
    run_vec(3, 1, 2, 1'b1);
    chk("bubble_sum", out_res, 32'd80);

    // abort a 5-element vector after 2 accepted pairs
    @(negedge clk);
    start = 1'b1;
    len   = 10'd5;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_a     = 8'd100 + 8'(i);
      in_b     = 8'd50;
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_res", out_res, 32'd0);
    @(negedge clk);
    rst   = 1'b0;
    va[0] = 8'd7;
    vb[0] = 8'hFD;
    run_vec(1, 0, 0, 1'b1);
    chk("after_rst", out_res, 32'(-21));

    for (int k = 0; k < 40; k++) begin
      run_vec($urandom_range(0, 16), $urandom_range(0, 2), $urandom_range(0, 3), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dp_seq_ctrl.md
# dp_seq_ctrl

Sequencer that turns the single-cycle 8×8 multiply datapath (unsigned `a` × signed `b`) into a full vector dot product. It accepts a start command with a vector length, streams element pairs in over a valid/ready handshake, and multiplies each pair through one internal multiplier with a registered product stage. It accumulates the products into a 32-bit signed sum and presents the result on a valid/ready output. It sits between the layer scheduler, which issues commands and consumes results, and the operand fetch logic, which supplies the element stream.

## Interface
- `LEN_W`, default 10: width of the vector-length field. Legal range is 1..16, which guarantees the 32-bit sum never overflows.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous reset, active-high.
- `start` in 1: command strobe. Sampled only in IDLE.
- `len` in LEN_W: number of element pairs. Latched on an accepted `start`. 0 is legal.
- `busy` out 1: high whenever the state is not IDLE.
- `in_valid` in 1: element pair valid.
- `in_ready` out 1: ready to accept a pair.
- `in_a` in 8: unsigned operand.
- `in_b` in 8: signed operand.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `out_res` out 32: signed dot-product result.

## Operation
- Product rule: `prod = $signed({1'b0,in_a}) * $signed(in_b)`, sign-extended to 32 bits.
- The accumulator is 32-bit two's complement. It cannot overflow for `LEN_W` ≤ 16, because 255·128·65535 < 2^31.
- States:
  - IDLE: `start`=1 latches `len` into `remaining`, clears `acc` and the product-valid flag. Next state is RUN if `len`≠0, else DONE.
  - RUN: `in_ready` = 1. Each handshake (`in_valid` & `in_ready`) loads the product register, sets `p_vld`, and decrements `remaining`. The handshake that takes `remaining` from 1 to 0 moves the state to DRAIN.
  - DRAIN: `in_ready` = 0. Exactly one cycle, letting the final product add into `acc`. Next state is DONE.
  - DONE: `out_valid` = 1 and `out_res` = `acc`, both held stable until `out_ready`=1. The output handshake moves the state to IDLE.
- Accumulate: on every edge where `p_vld`=1, `acc <= acc + prod_reg`. `p_vld` clears on any edge without an input handshake.
- `start` outside IDLE is ignored, including in the cycle of the output handshake. A new command is accepted no earlier than the cycle after the return to IDLE.
- Input bubbles in RUN (`in_valid`=0) stall the count. Neither the sum nor `remaining` changes.
- `in_a`/`in_b` are don't-care when not handshaking. `in_ready` is 0 in IDLE, DRAIN and DONE.
- Reset, including mid-operation: state=IDLE, `acc`=0, `remaining`=0, `p_vld`=0, `prod_reg`=0. Any in-flight vector is discarded and no result is produced.

## Timing
- Reset values of outputs: `busy`=0, `in_ready`=0, `out_valid`=0, `out_res`=0.
- `start` accepted at edge T: `busy`=1 and `in_ready`=1 from cycle T+1 (or `out_valid`=1 from T+1 when `len`=0).
- Last element accepted at edge L: the product is registered at L, added into `acc` at edge L+1 (the DRAIN cycle), and `out_valid`=1 from cycle L+2.
- With no input bubbles and no output backpressure, `start` to `out_valid` is `len`+2 cycles.
- `len`=0: `out_valid`=1 in the cycle after `start`, with `out_res`=0.
- Output handshake at edge H: `out_valid`=0 and `busy`=0 from cycle H+1. `out_res` holds its last value until the next `start`.
- The block is fully synchronous apart from `rst`. All outputs are registered or decoded from state only; there are no combinational paths from inputs to outputs.

## Test plan
- Basic vector: `len`=4, a={1,2,3,4}, b={1,-1,2,-2}, `out_ready`=1. Require `out_res`=-3, `out_valid` 6 cycles after `start`, and exactly 4 `in_ready` handshakes.
- Extremes: `len`=3, a=255, b=-128 each. Require `out_res`=-97920. Then `len`=2, a=255, b=127 each. Require 64770.
- Zero length and backpressure: `len`=0 → `out_res`=0 and `out_valid` the next cycle. Hold `out_ready`=0 for 5 cycles: `out_valid` and `out_res` stay stable and `start` pulses are ignored. Release `out_ready` → `busy`=0 the next cycle.
- Input bubbles: `len`=3, a={10,20,30}, b={-5,5,1}, with `in_valid` low on alternate cycles. Require `out_res`=80 and no extra or missing handshakes.
- Reset mid-run: assert `rst` after 2 of 5 elements. Require all outputs 0 immediately. A fresh `len`=1, a=7, b=-3 command then yields -21 with no residue from the aborted vector.
